// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller: default
// widths, FSM state encoding and command-record layout.
package regfile_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int ADDR_W_DEF     = 3;
   localparam int FIFO_DEPTH_DEF = 4;

   // Command record is {wr, addr, data}, wr in the MSB.
   localparam int CMD_WR_W = 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE_WR = 3'd1,
      ST_ISSUE_RD = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_RESP     = 3'd4
   } state_t;

   // Total width of one queued command record.
   function automatic int cmd_width(input int data_w, input int addr_w);
      return CMD_WR_W + addr_w + data_w;
   endfunction

endpackage

// File: rtl/regfile_cmd_fifo.sv
// Command queue: power-of-two depth, pointers carry one extra wrap bit so
// full and empty are told apart without an occupancy counter.
module regfile_cmd_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   // A push while full or a pop while empty is dropped here, so callers may
   // present raw requests.
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;
   assign o_empty    = (r_wr_ptr == r_rd_ptr);
   assign o_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign o_pop_data = r_mem[r_rd_ptr[PTR_W-1:0]];

   // Pointer update; wrap is implicit in the PTR_W+1 bit arithmetic.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: entries are unreachable once the pointers clear.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller. Commands are queued, then executed one
// at a time in acceptance order; reads hold their response until taken.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Valid, once raised by a producer, stays high with stable payload until
// the transfer; ready may change freely and never depends on valid.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Req_Wr,
   input  logic [ADDR_W-1:0] Req_Addr,
   input  logic [DATA_W-1:0] Req_Data,
   output logic              Rsp_Valid,
   input  logic              Rsp_Ready,
   output logic [DATA_W-1:0] Rsp_Data,
   output logic              RF_WrEn,
   output logic              RF_RdEn,
   output logic [ADDR_W-1:0] RF_Address,
   output logic [DATA_W-1:0] RF_WrData,
   input  logic [DATA_W-1:0] RF_RdData,
   output logic              Busy,
   output logic [2:0]        o_dbg_state
);

   localparam int CMD_W = cmd_width(DATA_W, ADDR_W);

   state_t            r_state;
   logic              r_cap_wait;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rf_wren;
   logic              r_rf_rden;
   logic [ADDR_W-1:0] r_rf_address;
   logic [DATA_W-1:0] r_rf_wrdata;

   logic [CMD_W-1:0]  w_push_data;
   logic [CMD_W-1:0]  w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_head_wr;
   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;

   assign w_push_data = {Req_Wr, Req_Addr, Req_Data};
   assign w_head_wr   = w_head[CMD_W-1];
   assign w_head_addr = w_head[DATA_W +: ADDR_W];
   assign w_head_data = w_head[DATA_W-1:0];

   // Only IDLE consumes; a fresh push into an empty queue is seen next cycle.
   assign w_pop = (r_state == ST_IDLE) && !w_empty;

   regfile_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .i_clk       (CLK),
      .i_rst_n     (RST),
      .i_push      (Req_Valid),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign Req_Ready   = !w_full;
   assign Busy        = !w_empty || (r_state != ST_IDLE);
   assign Rsp_Valid   = r_rsp_valid;
   assign Rsp_Data    = r_rsp_data;
   assign RF_WrEn     = r_rf_wren;
   assign RF_RdEn     = r_rf_rden;
   assign RF_Address  = r_rf_address;
   assign RF_WrData   = r_rf_wrdata;
   assign o_dbg_state = r_state;

   // Command FSM with registered RF and response outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= ST_IDLE;
         r_cap_wait   <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rf_wren    <= 1'b0;
         r_rf_rden    <= 1'b0;
         r_rf_address <= '0;
         r_rf_wrdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_rf_address <= w_head_addr;
                  r_rf_wrdata  <= w_head_data;
                  if (w_head_wr) begin
                     r_rf_wren <= 1'b1;
                     r_state   <= ST_ISSUE_WR;
                  end else begin
                     r_rf_rden <= 1'b1;
                     r_state   <= ST_ISSUE_RD;
                  end
               end
            end
            ST_ISSUE_WR: begin
               r_rf_wren <= 1'b0;
               r_state   <= ST_IDLE;
            end
            ST_ISSUE_RD: begin
               r_rf_rden  <= 1'b0;
               r_cap_wait <= 1'b1;
               r_state    <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // First cycle lets the RF output register settle after the
               // RdEn edge; the second cycle takes the data.
               if (r_cap_wait) begin
                  r_cap_wait <= 1'b0;
               end else begin
                  r_rsp_data  <= RF_RdData;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (Rsp_Ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of write/read data.
REQ-002 SHALL have parameter ADDR_W, default 3, width of register address (8 entries).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have port Req_Valid  input  1  requester offers a command.
REQ-007 SHALL have port Req_Ready  output  1  command queue can accept.
REQ-008 SHALL have port Req_Wr  input  1  1 = write, 0 = read.
REQ-009 SHALL have port Req_Addr  input  ADDR_W  target register.
REQ-010 SHALL have port Req_Data  input  DATA_W  write data (ignored for reads).
REQ-011 SHALL have port Rsp_Valid  output  1  read data available.
REQ-012 SHALL have port Rsp_Ready  input  1  consumer takes read data.
REQ-013 SHALL have port Rsp_Data  output  DATA_W  read result.
REQ-014 SHALL have port RF_WrEn  output  1  write enable to register file.
REQ-015 SHALL have port RF_RdEn  output  1  read enable to register file.
REQ-016 SHALL have port RF_Address  output  ADDR_W  register file address.
REQ-017 SHALL have port RF_WrData  output  DATA_W  register file write data.
REQ-018 SHALL have port RF_RdData  input  DATA_W  registered register-file read data, valid the cycle after the RF_RdEn edge.
REQ-019 SHALL have port Busy  output  1  high when queue non-empty or FSM not IDLE.

Function
REQ-020 SHALL push {Req_Wr, Req_Addr, Req_Data} into the queue on any edge where Req_Valid && Req_Ready.
REQ-021 SHALL drive Req_Ready = !full, combinationally from queue state only; no push when full even if a pop occurs that cycle.
REQ-022 SHALL implement FSM states IDLE, ISSUE_WR, ISSUE_RD, CAPTURE, RESP.
REQ-023 IDLE: if queue non-empty, pop head into command registers and go to ISSUE_WR (Req_Wr=1) or ISSUE_RD (Req_Wr=0); else stay.
REQ-024 ISSUE_WR: RF_WrEn=1, RF_RdEn=0 for exactly one cycle, RF_Address/RF_WrData from command registers; next IDLE.
REQ-025 ISSUE_RD: RF_RdEn=1, RF_WrEn=0 for exactly one cycle; next CAPTURE.
REQ-026 CAPTURE: register RF_RdData into Rsp_Data, set Rsp_Valid=1; next RESP.
REQ-027 RESP: hold Rsp_Valid and Rsp_Data stable until Rsp_Ready; on Rsp_Valid && Rsp_Ready clear Rsp_Valid and go IDLE.
REQ-028 SHALL never assert RF_WrEn and RF_RdEn in the same cycle; both SHALL be 0 in IDLE, CAPTURE, RESP.
REQ-029 SHALL execute commands strictly in acceptance order; no new command issued while a response is pending.
REQ-030 Latency: write accepted at edge N reaches RF_WrEn high in cycle N+1..N+2 (queue empty, FSM IDLE) -- pop edge N+1, RF write edge N+2.
REQ-031 Latency: read accepted at edge N with idle FSM SHALL show Rsp_Valid=1 after edge N+4 (pop, RdEn, RF update, capture).
REQ-032 Queue pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.
REQ-033 Simultaneous push and pop on a non-full, non-empty queue SHALL leave occupancy unchanged.
REQ-034 Push into an empty queue while FSM IDLE SHALL not pop the same cycle (entry visible to IDLE the following cycle).

Reset
REQ-035 On RST low, immediately: queue empty, pointers 0, FSM IDLE, Rsp_Valid=0, Rsp_Data=0, RF_WrEn=0, RF_RdEn=0, RF_Address=0, RF_WrData=0, Busy=0, Req_Ready=1.
REQ-036 Reset mid-operation SHALL discard queued and in-flight commands and any pending response; no partial RF write after release.

Structure
REQ-037 Shared package regfile_pkg SHALL hold DATA_W/ADDR_W defaults, FSM state encoding, and command-record field widths.
REQ-038 Command queue SHALL be a separate sub-module regfile_cmd_fifo (push/pop/full/empty, async active-low reset).

Verification
REQ-039 Write 0xA5A5 to addr 3, then read addr 3 -> RF_WrEn one cycle with addr 3/0xA5A5; Rsp_Data=0xA5A5, Rsp_Valid after edge N+4.
REQ-040 Push 5 commands back-to-back with FSM stalled in RESP (Rsp_Ready=0) -> Req_Ready falls after 4th accepted; 5th held until a pop.
REQ-041 Read addr 7 with Rsp_Ready=0 for 10 cycles -> Rsp_Valid and Rsp_Data stable all 10 cycles; no RF enables asserted.
REQ-042 Writes 0x1111..0x8888 to addrs 0..7 then reads 0..7 -> responses in order match; RF_WrEn&&RF_RdEn never both 1.
REQ-043 Assert RST during CAPTURE of a read -> Rsp_Valid=0, queue empty, Busy=0 immediately; no response after release.
REQ-044 Sustained push/pop for 20 commands -> pointers wrap correctly, no loss or duplication.
